// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register file write-port arbiter between pipeline WB and a long-latency unit
module wb_port_arbiter #(
    parameter int X_LEN    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pipe_wb_en_i,
    input  logic [4:0]       pipe_rd_i,
    input  logic [X_LEN-1:0] pipe_data_i,
    input  logic             llu_issue_i,
    input  logic [4:0]       llu_issue_rd_i,
    input  logic             llu_valid_i,
    input  logic [4:0]       llu_rd_i,
    input  logic [X_LEN-1:0] llu_data_i,
    output logic             llu_ready_o,
    output logic             stall_wb_o,
    output logic             reg_write_o,
    output logic [4:0]       rd_addr_o,
    output logic [X_LEN-1:0] wb_data_o,
    output logic [31:0]      busy_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONTEND,
        S_FORCE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [31:0]     busy_q, busy_d;

    logic            pipe_req;
    logic            llu_x0;
    logic            grant_pipe;
    logic            grant_llu;
    logic            stall;
    logic            transfer;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;

    assign pipe_req = pipe_wb_en_i && (pipe_rd_i != 5'd0);
    assign llu_x0   = llu_valid_i && (llu_rd_i == 5'd0);

    always_comb begin
        state_d    = S_IDLE;
        wait_d     = '0;
        grant_pipe = 1'b0;
        grant_llu  = 1'b0;
        stall      = 1'b0;
        case (state_q)
            S_FORCE: begin
                if (llu_valid_i) begin
                    grant_llu = 1'b1;
                    stall     = 1'b1;
                end else begin
                    grant_pipe = pipe_req;
                end
            end
            default: begin
                if (llu_valid_i && (!pipe_req || llu_x0)) begin
                    // An x0 result uses no port, so the pipe write proceeds alongside it
                    grant_llu  = 1'b1;
                    grant_pipe = pipe_req;
                end else if (llu_valid_i) begin
                    grant_pipe = 1'b1;
                    wait_d     = wait_q + 1'b1;
                    state_d    = (wait_d >= CW'(MAX_WAIT)) ? S_FORCE : S_CONTEND;
                end else begin
                    grant_pipe = pipe_req;
                end
            end
        endcase
    end

    always_comb begin
        llu_ready_o = 1'b0;
        stall_wb_o  = 1'b0;
        reg_write_o = 1'b0;
        rd_addr_o   = 5'd0;
        wb_data_o   = '0;
        if (rst_n_i) begin
            llu_ready_o = grant_llu;
            stall_wb_o  = stall;
            if (grant_llu && !llu_x0) begin
                reg_write_o = 1'b1;
                rd_addr_o   = llu_rd_i;
                wb_data_o   = llu_data_i;
            end else if (grant_pipe) begin
                reg_write_o = 1'b1;
                rd_addr_o   = pipe_rd_i;
                wb_data_o   = pipe_data_i;
            end
        end
    end

    assign transfer = llu_valid_i && llu_ready_o;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (llu_issue_i && (llu_issue_rd_i != 5'd0)) begin
            set_mask = 32'd1 << llu_issue_rd_i;
        end
        if (transfer && (llu_rd_i != 5'd0)) begin
            clr_mask = 32'd1 << llu_rd_i;
        end
        // Set wins over clear: a re-issue to the retiring register stays outstanding
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter against a reference model
module tb_wb_port_arbiter;

    localparam int X_LEN    = 32;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pipe_wb_en;
    logic [4:0]       pipe_rd;
    logic [X_LEN-1:0] pipe_data;
    logic             llu_issue;
    logic [4:0]       llu_issue_rd;
    logic             llu_valid;
    logic [4:0]       llu_rd;
    logic [X_LEN-1:0] llu_data;
    logic             llu_ready;
    logic             stall_wb;
    logic             reg_write;
    logic [4:0]       rd_addr;
    logic [X_LEN-1:0] wb_data;
    logic [31:0]      busy;

    wb_port_arbiter #(.X_LEN(X_LEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .pipe_wb_en_i   (pipe_wb_en),
        .pipe_rd_i      (pipe_rd),
        .pipe_data_i    (pipe_data),
        .llu_issue_i    (llu_issue),
        .llu_issue_rd_i (llu_issue_rd),
        .llu_valid_i    (llu_valid),
        .llu_rd_i       (llu_rd),
        .llu_data_i     (llu_data),
        .llu_ready_o    (llu_ready),
        .stall_wb_o     (stall_wb),
        .reg_write_o    (reg_write),
        .rd_addr_o      (rd_addr),
        .wb_data_o      (wb_data),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: count of consecutive cycles the LLU lost to the pipe, plus a busy bitmap
    int               denied = 0;
    logic [31:0]      busy_m = '0;
    logic             e_ready, e_stall, e_we, e_deny, xfer_m;
    logic [4:0]       e_addr;
    logic [X_LEN-1:0] e_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_outputs();
        logic preq, lv, lx0, force_now;
        preq      = pipe_wb_en && (pipe_rd != 0);
        lv        = llu_valid;
        lx0       = lv && (llu_rd == 0);
        force_now = lv && (denied >= MAX_WAIT);
        e_ready = 0; e_stall = 0; e_we = 0; e_addr = 0; e_data = 0; e_deny = 0;
        if (!rst_n) begin
            denied = 0;
            busy_m = '0;
        end else if (force_now) begin
            e_ready = 1; e_stall = 1;
            if (!lx0) begin e_we = 1; e_addr = llu_rd; e_data = llu_data; end
        end else if (lv && !lx0 && !preq) begin
            e_ready = 1; e_we = 1; e_addr = llu_rd; e_data = llu_data;
        end else begin
            e_ready = lx0;
            e_deny  = lv && !lx0 && preq;
            if (preq) begin e_we = 1; e_addr = pipe_rd; e_data = pipe_data; end
        end
        xfer_m = rst_n && lv && e_ready;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            denied = 0;
            busy_m = '0;
        end else begin
            denied = e_deny ? denied + 1 : 0;
            if (xfer_m && llu_rd != 0) busy_m[llu_rd] = 1'b0;
            if (llu_issue && llu_issue_rd != 0) busy_m[llu_issue_rd] = 1'b1;
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked at the falling edge
    task automatic step(input string name);
        #4;
        model_outputs();
        check({name, "/ready"}, 64'(llu_ready), 64'(e_ready));
        check({name, "/stall"}, 64'(stall_wb),  64'(e_stall));
        check({name, "/we"},    64'(reg_write), 64'(e_we));
        check({name, "/addr"},  64'(rd_addr),   64'(e_addr));
        check({name, "/data"},  64'(wb_data),   64'(e_data));
        check({name, "/busy"},  64'(busy),      64'(busy_m));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_pipe(input logic en, input logic [4:0] rd, input logic [X_LEN-1:0] d);
        pipe_wb_en = en; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic set_llu(input logic v, input logic [4:0] rd, input logic [X_LEN-1:0] d);
        llu_valid = v; llu_rd = rd; llu_data = d;
    endtask

    initial begin
        rst_n = 0; llu_issue = 0; llu_issue_rd = 0;
        set_pipe(1, 5, 32'h55);
        set_llu(1, 7, 32'h77);
        @(posedge clk); #1;

        step("reset0");
        step("reset1");
        rst_n = 1;
        set_pipe(0, 0, 0);
        set_llu(0, 0, 0);
        step("post_reset");

        set_pipe(1, 5, 32'hAA);
        step("pipe_only");

        set_llu(1, 7, 32'h1234);
        for (int i = 0; i < 6; i++) begin
            set_pipe(1, 5'(1 + i), 32'(32'h100 + i));
            step($sformatf("contend%0d", i));
            if (xfer_m) set_llu(0, 0, 0);
        end
        set_pipe(0, 0, 0);
        set_llu(0, 0, 0);

        llu_issue = 1; llu_issue_rd = 9;
        step("issue9");
        llu_issue = 0;
        step("busy9");
        set_llu(1, 9, 32'h9999);
        step("retire9");
        set_llu(0, 0, 0);
        step("busy_clear");
        llu_issue = 1;
        step("reissue9");
        set_llu(1, 9, 32'h9A9A);
        step("issue_retire9");
        llu_issue = 0;
        set_llu(0, 0, 0);
        step("set_wins");

        set_llu(1, 0, 32'hDEAD);
        set_pipe(1, 3, 32'h333);
        step("llu_x0_pipe3");
        set_llu(1, 4, 32'h444);
        set_pipe(1, 0, 32'hBAD);
        step("pipe_x0_llu4");
        set_llu(0, 0, 0);
        set_pipe(0, 0, 0);
        step("idle");

        set_llu(1, 6, 32'h6666);
        set_pipe(1, 2, 32'h222);
        step("pre_rst0");
        step("pre_rst1");
        rst_n = 0;
        step("mid_reset");
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            set_pipe(1, 2, 32'(32'h200 + i));
            step($sformatf("fresh%0d", i));
            if (xfer_m) set_llu(0, 0, 0);
        end
        set_pipe(0, 0, 0);
        set_llu(0, 0, 0);
        step("quiet");

        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_pipe(($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                     $urandom);
            if (!llu_valid && $urandom_range(0, 2) == 0) begin
                set_llu(1, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom);
            end
            llu_issue    = ($urandom_range(0, 3) == 0);
            llu_issue_rd = 5'($urandom);
            step($sformatf("rand%0d", i));
            if (xfer_m) set_llu(0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writers: the in-order pipeline WB stage and a long-latency unit (LLU, e.g. mul/div/load-miss).
- Pipeline has priority. The LLU uses a valid/ready handshake, and a starvation counter forces a one-cycle WB stall so the LLU can retire.
- Keeps a 32-bit busy scoreboard of registers with LLU results outstanding, consumed by the hazard unit.
- Outputs drive the register file's write-enable/address/data inputs directly.

Parameters:
- X_LEN, 32, data width.
- MAX_WAIT, 4, consecutive denied LLU cycles before a forced grant (legal range >= 1).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- pipe_wb_en_i  in  1  pipeline WB stage requests a write.
- pipe_rd_i  in  5  pipeline destination register.
- pipe_data_i  in  X_LEN  pipeline write data.
- llu_issue_i  in  1  LLU op issued this cycle.
- llu_issue_rd_i  in  5  destination of the issued LLU op.
- llu_valid_i  in  1  LLU result available.
- llu_rd_i  in  5  LLU result destination.
- llu_data_i  in  X_LEN  LLU result data.
- llu_ready_o  out  1  LLU result accepted this cycle (combinational).
- stall_wb_o  out  1  pipeline WB must hold this cycle; its request is ignored.
- reg_write_o  out  1  register file write enable.
- rd_addr_o  out  5  register file write address.
- wb_data_o  out  X_LEN  register file write data.
- busy_o  out  32  scoreboard; bit n = LLU write to xn outstanding.

Behaviour:
Reset:
- While rst_n_i=0, all combinational outputs are forced to 0: llu_ready_o, stall_wb_o, reg_write_o, rd_addr_o, wb_data_o.
- busy_o=0, wait_cnt=0, state=IDLE.
- Reset asserted mid-contention abandons the pending LLU result; the LLU re-presents it after reset.

Request qualification:
- pipe_req = pipe_wb_en_i & (pipe_rd_i!=0).
- A pipeline write to x0 is never a request.

State machine (registered state, combinational grant, zero-cycle latency):
- IDLE:
  - llu_valid_i & !pipe_req: grant LLU.
  - llu_valid_i & pipe_req: grant pipe; wait_cnt=1; go to CONTEND. If MAX_WAIT=1, go to FORCE instead.
- CONTEND:
  - pipe_req & llu_valid_i: grant pipe; wait_cnt++; go to FORCE when wait_cnt reaches MAX_WAIT.
  - LLU granted (no pipe_req): go to IDLE, wait_cnt=0.
  - llu_valid_i drops: go to IDLE, wait_cnt=0.
- FORCE:
  - stall_wb_o=1 whenever llu_valid_i=1, regardless of pipe_wb_en_i.
  - LLU is granted; next state IDLE, wait_cnt=0.
  - If llu_valid_i=0 in FORCE: no stall, go to IDLE.

Grant outputs:
- Pipe grant: reg_write_o=1, rd_addr_o=pipe_rd_i, wb_data_o=pipe_data_i, llu_ready_o=0.
- LLU grant: llu_ready_o=1. If llu_rd_i!=0: reg_write_o=1, rd_addr_o=llu_rd_i, wb_data_o=llu_data_i.
- LLU result to x0: accepted with llu_ready_o=1 and reg_write_o=0. It is granted even when pipe_req=1, because it consumes no port and the pipe write is also performed.
- No grant: reg_write_o=0, rd_addr_o=0, wb_data_o=0.

LLU handshake:
- LLU holds llu_rd_i/llu_data_i stable while llu_valid_i=1 and llu_ready_o=0.
- Transfer occurs on a clock edge with valid & ready both 1.

Scoreboard:
- llu_issue_i with llu_issue_rd_i!=0 sets busy[rd] at the edge.
- LLU transfer with llu_rd_i!=0 clears busy[llu_rd_i] at the edge.
- Set and clear of the same bit in the same cycle: set wins (new issue outstanding).
- busy[0] is always 0.
- Issue to an already-busy register, or a pipe write to a busy register, is prevented upstream by the hazard unit and is not checked here.

Test Plan:
- Reset with llu_valid_i=1, pipe_wb_en_i=1 -> all outputs 0 during reset; busy_o=0 after release.
- pipe_wb_en_i=1, rd=5, data=0xAA, llu idle -> same cycle reg_write_o=1, rd_addr_o=5, wb_data_o=0xAA, llu_ready_o=0.
- MAX_WAIT=4, pipe writes every cycle, LLU valid rd=7 data=0x1234:
  - Cycles 0-3 pipe granted, llu_ready_o=0.
  - Cycle 4: stall_wb_o=1, reg_write_o=1, rd_addr_o=7, wb_data_o=0x1234, llu_ready_o=1.
  - Cycle 5 pipe resumes.
- llu_issue_i rd=9 -> busy_o=0x200 next cycle; LLU retires rd=9 -> busy_o=0 after the transfer edge. Issue rd=9 and retire rd=9 in the same cycle -> busy_o stays 0x200.
- LLU result rd=0 concurrent with pipe rd=3 -> llu_ready_o=1, reg_write_o=1, rd_addr_o=3, no stall. Pipe rd=0 with LLU rd=4 -> LLU written.
- Assert rst_n_i in CONTEND (wait_cnt=2) -> outputs 0 immediately. After release, the first contention stalls only after 4 fresh denied cycles.
